// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: radix-2 shift-add multiply, restoring divide.
// Optional MULDIV_EARLY_OUT_EN lets MUL stop once the remaining multiplier is zero.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);
    // state  | meaning
    // S_IDLE | waiting for start_i
    // S_MUL  | shift-add iterations
    // S_DIV  | restoring-divide iterations
    // S_FIX  | sign correction and result select
    // S_FAST | divide-by-zero / signed-overflow result
    // S_DONE | result presented for one cycle
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_FAST, S_DONE} state_t;
    state_t state_q, state_d;

    logic [2:0]      op_q;
    logic [XLEN:0]   a_q;        // |multiplicand| or |divisor|
    logic [XLEN-1:0] b_q;        // shifting multiplier, or raw rs1 for divides
    logic [2*XLEN:0] acc_q;      // product accumulator, or {rem, quo}
    logic [CW-1:0]   count_q;
    logic            neg_q, sa_q, dz_q;
    logic [XLEN-1:0] result_q;

    logic            accept, signed_a, signed_b, sign_a, sign_b;
    logic            div_zero, div_ovf, fast, last_iter, mul_exit;
    logic [XLEN:0]   abs_a, abs_b;

    assign accept    = (state_q == S_IDLE) && start_i && !flush_i;
    assign signed_a  = op_i[2] ? ~op_i[0] : (op_i[1:0] != 2'd3);
    assign signed_b  = op_i[2] ? ~op_i[0] : ~op_i[1];
    assign sign_a    = signed_a & rs1_i[XLEN-1];
    assign sign_b    = signed_b & rs2_i[XLEN-1];
    assign abs_a     = sign_a ? (~{1'b1, rs1_i} + (XLEN+1)'(1)) : {1'b0, rs1_i};
    assign abs_b     = sign_b ? (~{1'b1, rs2_i} + (XLEN+1)'(1)) : {1'b0, rs2_i};
    assign div_zero  = (rs2_i == '0);
    assign div_ovf   = ~op_i[0] && (rs1_i == MIN_NEG) && (&rs2_i);
    assign fast      = op_i[2] && (div_zero || div_ovf);
    assign last_iter = (count_q == CW'(XLEN-1));
`ifdef MULDIV_EARLY_OUT_EN
    assign mul_exit  = last_iter || (b_q[XLEN-1:1] == '0);
`else
    assign mul_exit  = last_iter;
`endif

    logic [XLEN+1:0] mul_sum, div_diff;
    logic [XLEN:0]   rem_sh;
    logic [2*XLEN:0] mul_next, div_next;

    assign mul_sum  = {1'b0, acc_q[2*XLEN:XLEN]} + {1'b0, a_q};
    assign mul_next = b_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN:1]};
    assign rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff = {1'b0, rem_sh} - {1'b0, a_q};
    assign div_next = div_diff[XLEN+1] ? {rem_sh, acc_q[XLEN-2:0], 1'b0}
                                       : {div_diff[XLEN:0], acc_q[XLEN-2:0], 1'b1};

    logic [2*XLEN-1:0] prod_abs, prod;
    logic [XLEN-1:0]   quo, rem, fix_res, fast_res;
    logic [CW-1:0]     realign;

    // count_q equals the iteration count mod XLEN in FIX, so -count is the missing shift
    assign realign = -count_q;
`ifdef MULDIV_EARLY_OUT_EN
    assign prod_abs = acc_q[2*XLEN-1:0] >> realign;
`else
    assign prod_abs = acc_q[2*XLEN-1:0];
`endif
    assign prod = neg_q ? -prod_abs : prod_abs;
    assign quo  = acc_q[XLEN-1:0];
    assign rem  = acc_q[2*XLEN-1:XLEN];

    always_comb begin
        fix_res = '0;
        case (op_q)
            3'd0:         fix_res = prod[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:         fix_res = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:   fix_res = neg_q ? -quo : quo;
            default:      fix_res = sa_q ? -rem : rem;
        endcase
    end

    assign fast_res = dz_q ? (op_q[1] ? b_q : '1) : (op_q[1] ? '0 : MIN_NEG);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        stall_o = 1'b0;
        case (state_q)
            S_IDLE: if (accept) begin
                stall_o = 1'b1;
                state_d = fast ? S_FAST : (op_i[2] ? S_DIV : S_MUL);
            end
            S_MUL: begin
                stall_o = 1'b1;
                if (mul_exit) state_d = S_FIX;
            end
            S_DIV: begin
                stall_o = 1'b1;
                if (last_iter) state_d = S_FIX;
            end
            S_FIX, S_FAST: begin
                stall_o = 1'b1;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush_i && state_q != S_IDLE) state_d = S_IDLE;
    end

    assign busy_o   = (state_q != S_IDLE);
    assign done_o   = (state_q == S_DONE);
    assign result_o = done_o ? result_q : '0;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            neg_q    <= 1'b0;
            sa_q     <= 1'b0;
            dz_q     <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    op_q    <= op_i;
                    count_q <= '0;
                    neg_q   <= sign_a ^ sign_b;
                    sa_q    <= sign_a;
                    dz_q    <= div_zero;
                    if (op_i[2]) begin
                        a_q   <= abs_b;
                        b_q   <= rs1_i;
                        acc_q <= {{(XLEN+1){1'b0}}, abs_a[XLEN-1:0]};
                    end else begin
                        a_q   <= abs_a;
                        b_q   <= abs_b[XLEN-1:0];
                        acc_q <= '0;
                    end
                end
                S_MUL: begin
                    acc_q   <= mul_next;
                    b_q     <= b_q >> 1;
                    count_q <= count_q + CW'(1);
                end
                S_DIV: begin
                    acc_q   <= div_next;
                    count_q <= count_q + CW'(1);
                end
                S_FIX:   result_q <= fix_res;
                S_FAST:  result_q <= fast_res;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed vectors, latency, stall, flush and async reset.
module tb_muldiv_seq;
    localparam int XLEN = 32;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EO = 1'b1;
`else
    localparam bit EO = 1'b0;
`endif

    logic            clk_i = 1'b0;
    logic            rstn_i = 1'b0;
    logic            start_i = 1'b0;
    logic [2:0]      op_i = '0;
    logic [XLEN-1:0] rs1_i = '0;
    logic [XLEN-1:0] rs2_i = '0;
    logic            flush_i = 1'b0;
    logic            stall_o, done_o, busy_o;
    logic [XLEN-1:0] result_o;

    muldiv_seq #(.XLEN(XLEN)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .op_i(op_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .flush_i(flush_i),
        .stall_o(stall_o), .done_o(done_o), .result_o(result_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          at;
        string       name;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int passed = 0;
    int n_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // monitor: pops the scoreboard whenever the DUT presents a result
    always @(negedge clk_i) begin
        if (rstn_i && done_o === 1'b1) begin
            n_done++;
            if (exp_q.size() == 0) begin
                check("unexpected done_o", 32'(done_o), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, " result"}, result_o, e.res);
                check({e.name, " done cycle"}, 32'(cyc), 32'(e.at));
            end
        end
    end

    task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input int lat);
        exp_t e;
        int   stl;
        bit   ok;
        e.res = res; e.at = cyc + lat; e.name = name;
        exp_q.push_back(e);
        start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b;
        #1;
        check({name, " stall on start"}, 32'(stall_o), 32'd1);
        stl = 1;
        ok  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk_i); #1;
            start_i = 1'b0;
            if (done_o) begin ok = 1'b1; break; end
            if (stall_o) stl++;
        end
        if (!ok) begin
            check({name, " timeout waiting done_o"}, 32'd0, 32'd1);
            exp_q.delete();
        end else begin
            check({name, " stall cycles"}, 32'(stl), 32'(lat));
        end
        @(negedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, nd0;
        #12;
        check("reset stall_o", 32'(stall_o), 32'd0);
        check("reset busy_o", 32'(busy_o), 32'd0);
        check("reset done_o", 32'(done_o), 32'd0);
        check("reset result_o", result_o, 32'd0);
        @(negedge clk_i); rstn_i = 1'b1;
        @(negedge clk_i);

        issue("MUL 7*-3",        3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, EO ? 4 : 34);
        issue("MULHU max*max",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        issue("MULH -1*-1",      3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, EO ? 3 : 34);
        issue("MULHSU -1*2",     3'd2, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, EO ? 4 : 34);
        issue("MULH min*min",    3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
        issue("DIV -7/2",        3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 34);
        issue("REM -7%2",        3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 34);
        issue("DIVU 100/7",      3'd5, 32'd100,      32'd7,        32'd14,        34);
        issue("REMU 100%7",      3'd7, 32'd100,      32'd7,        32'd2,         34);
        issue("DIV min/2",       3'd4, 32'h8000_0000, 32'd2,        32'hC000_0000, 34);
        issue("DIVU by zero",    3'd5, 32'h0000_1234, 32'd0,        32'hFFFF_FFFF, 2);
        issue("REM by zero",     3'd6, 32'h0000_1234, 32'd0,        32'h0000_1234, 2);
        issue("DIV overflow",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        issue("REM overflow",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2);

        // flush a DIV at T+10, then start a DIVU at T+11
        t0 = cyc;
        start_i = 1'b1; op_i = 3'd4; rs1_i = 32'hFFFF_FF9C; rs2_i = 32'd3;
        @(posedge clk_i); #1; start_i = 1'b0;
        repeat (9) @(posedge clk_i);
        #1;
        check("flush at T+10", 32'(cyc - t0), 32'd10);
        flush_i = 1'b1;
        nd0 = n_done;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        check("busy_o after flush", 32'(busy_o), 32'd0);
        issue("DIVU 9/3 after flush", 3'd5, 32'd9, 32'd3, 32'd3, 34);
        check("done pulses after flush", 32'(n_done - nd0), 32'd1);

        // asynchronous reset mid-MUL
        start_i = 1'b1; op_i = 3'd0; rs1_i = 32'd123; rs2_i = 32'hFFFF_0000;
        @(posedge clk_i); #1; start_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #3;
        check("busy before reset", 32'(busy_o), 32'd1);
        rstn_i = 1'b0;
        #1;
        check("async reset stall_o", 32'(stall_o), 32'd0);
        check("async reset busy_o", 32'(busy_o), 32'd0);
        check("async reset done_o", 32'(done_o), 32'd0);
        #10;
        @(negedge clk_i); rstn_i = 1'b1;
        @(negedge clk_i);
        issue("MUL 5*5 after reset", 3'd0, 32'd5, 32'd5, 32'd25, EO ? 5 : 34);

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
